// File: rtl/dm_sized.sv
// Byte-addressed data memory: sized loads/stores, wait states, req/ack.
// Define DM_ALIGN_CHECK_EN to trap misaligned/reserved accesses via err.
module dm_sized #(
  parameter int ADDR_W   = 12,
  parameter int DEPTH    = 1024,
  parameter int WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
  output logic              ready,
  output logic              ack,
  output logic [31:0]       dout,
  output logic              err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic              sext_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;
  logic [31:0]       dout_q;
  logic              err_q;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] ea;
  logic [AW-1:0]     b0, b1, b2, b3;
  logic [31:0]       rd, ld;
  logic              mis;
  logic              accept;
  logic              do_acc;

  assign ready  = (state_q == IDLE);
  assign ack    = (state_q == RESP);
  assign err    = ack & err_q;
  assign dout   = dout_q;
  assign accept = req & ready;
  assign do_acc = (state_q == BUSY) && (cnt_q == 4'd0);

  always_comb begin
    ea  = addr_q;
    mis = 1'b0;
`ifdef DM_ALIGN_CHECK_EN
    unique case (size_q)
      2'b01:   mis = addr_q[0];
      2'b10:   mis = |addr_q[1:0];
      2'b11:   mis = 1'b1;
      default: mis = 1'b0;
    endcase
`else
    if (size_q == 2'b01) ea[0] = 1'b0;
    else if (size_q[1]) ea[1:0] = 2'b00;
`endif
  end

  // Truncation to AW bits gives the modulo-DEPTH wrap.
  assign b0 = AW'(ea);
  assign b1 = AW'(ea + ADDR_W'(1));
  assign b2 = AW'(ea + ADDR_W'(2));
  assign b3 = AW'(ea + ADDR_W'(3));

  always_comb begin
    rd = {mem[b3], mem[b2], mem[b1], mem[b0]};
    ld = rd;
    unique case (size_q)
      2'b00:   ld = {{24{sext_q & rd[7]}}, rd[7:0]};
      2'b01:   ld = {{16{sext_q & rd[15]}}, rd[15:0]};
      default: ld = rd;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = BUSY;
          cnt_d   = 4'(WAIT_CYC);
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      din_q   <= 32'd0;
      dout_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q   <= we;
        sext_q <= sext;
        size_q <= size;
        addr_q <= addr;
        din_q  <= din;
      end
      if (do_acc) begin
        err_q <= mis;
        if (!we_q && !mis) dout_q <= ld;
      end
    end
  end

  // Write happens only on the access edge, so a reset before it drops the store.
  always_ff @(posedge clk) begin
    if (do_acc && we_q && !mis) begin
      mem[b0] <= din_q[7:0];
      if (size_q != 2'b00) mem[b1] <= din_q[15:8];
      if (size_q[1]) begin
        mem[b2] <= din_q[23:16];
        mem[b3] <= din_q[31:24];
      end
    end
  end

endmodule
